// File: rtl/stall_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : stall_ctrl_unit
// Purpose  : Pipeline stall controller. Detects halt, load and jump opcodes in
//            decode, stalls the PC and IF/ID stages for a fixed number of
//            cycles per hazard, holds a HALT state until resume, and counts
//            stalled cycles in a saturating counter.
// Ports    : clk       - single clock, rising edge
//            reset     - synchronous, active-high
//            op        - decode-stage opcode (held while stall=1)
//            valid     - op is a real instruction
//            resume    - one-cycle pulse releasing HALT
//            clr_cnt   - synchronous clear of stall_cnt
//            stall     - combinational stall to PC and IF/ID
//            stall_pm  - stall delayed one cycle, for program memory
//            halted    - registered HALT indication
//            stall_cnt - saturating count of stalled cycles
// Revision : 1.0 - initial release
// ============================================================================
module stall_ctrl_unit #(
  parameter int              OP_W      = 6,
  parameter logic [OP_W-1:0] OP_HLT    = 6'b010001,
  parameter logic [OP_W-1:0] OP_LD     = 6'b010100,
  parameter logic [OP_W-1:0] JMP_MASK  = 6'b111100,
  parameter logic [OP_W-1:0] JMP_MATCH = 6'b011100,
  parameter int              LD_CYC    = 1,
  parameter int              JMP_CYC   = 2,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             valid,
  input  logic             resume,
  input  logic             clr_cnt,
  output logic             stall,
  output logic             stall_pm,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  // Remaining-cycle preloads: the detection cycle is itself a stall cycle.
  localparam logic [3:0]       c_ld_rem  = 4'(LD_CYC - 1);
  localparam logic [3:0]       c_jmp_rem = 4'(JMP_CYC - 1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2,
    PASS = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic             stall_pm_q, stall_pm_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic w_hit_h, w_hit_l, w_hit_j;

  assign w_hit_h = valid && (op == OP_HLT);
  assign w_hit_l = valid && (op == OP_LD);
  assign w_hit_j = valid && ((op & JMP_MASK) == JMP_MATCH);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;

    case (state_q)
      IDLE: begin
        stall = w_hit_h || w_hit_l || w_hit_j;
        if (w_hit_h) begin
          state_d = HALT;
        end else if (w_hit_l) begin
          rem_d   = c_ld_rem;
          state_d = (c_ld_rem != 4'd0) ? WAIT : PASS;
        end else if (w_hit_j) begin
          rem_d   = c_jmp_rem;
          state_d = (c_jmp_rem != 4'd0) ? WAIT : PASS;
        end
      end
      WAIT: begin
        stall = 1'b1;
        rem_d = rem_q - 4'd1;
        if (rem_q == 4'd1) begin
          state_d = PASS;
        end
      end
      HALT: begin
        stall = 1'b1;
        if (resume) begin
          state_d = PASS;
        end
      end
      PASS: begin
        // Detection suppressed so the held instruction can advance.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      stall = 1'b0;
    end

    // halted rises with the edge entering HALT and stays up through the
    // releasing PASS cycle, dropping one cycle after HALT is left.
    halted_d   = (state_q == HALT) || (state_d == HALT);
    stall_pm_d = stall;

    stall_cnt_d = stall_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != c_cnt_max)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= 4'd0;
      stall_pm_q  <= 1'b0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_pm_q  <= stall_pm_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_pm  = stall_pm_q;
  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_stall_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_stall_ctrl_unit
// Purpose  : Self-checking bench for stall_ctrl_unit. Three instances share
//            the stimulus: defaults, JMP_CYC=4 and CNT_W=4. Each vector row
//            names the instance it checks; expected values are queued when
//            the row is driven and compared when the outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stall_ctrl_unit;

  localparam logic [5:0] c_nop = 6'b000000;
  localparam logic [5:0] c_hlt = 6'b010001;
  localparam logic [5:0] c_ld  = 6'b010100;
  localparam logic [5:0] c_jmp = 6'b011100;
  localparam logic [5:0] c_jmx = 6'b011110;  // also a jump under the mask

  typedef struct {
    int          seg;
    logic        rst;
    logic [5:0]  op;
    logic        vld;
    logic        res;
    logic        clr;
    int          sel;   // 0 defaults, 1 JMP_CYC=4, 2 CNT_W=4
    logic        chk;
    logic        e_stall;
    logic        e_pm;
    logic        e_halt;
    logic [15:0] e_cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = c_nop;
  logic       valid = 1'b0;
  logic       resume = 1'b0;
  logic       clr_cnt = 1'b0;

  logic        st0, pm0, ht0;
  logic [15:0] cn0;
  logic        st1, pm1, ht1;
  logic [15:0] cn1;
  logic        st2, pm2, ht2;
  logic [3:0]  cn2;

  int n_checks = 0;
  int n_errors = 0;

  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  stall_ctrl_unit u_dut (
    .clk(clk), .reset(reset), .op(op), .valid(valid), .resume(resume),
    .clr_cnt(clr_cnt), .stall(st0), .stall_pm(pm0), .halted(ht0), .stall_cnt(cn0)
  );

  stall_ctrl_unit #(.JMP_CYC(4)) u_dut_j4 (
    .clk(clk), .reset(reset), .op(op), .valid(valid), .resume(resume),
    .clr_cnt(clr_cnt), .stall(st1), .stall_pm(pm1), .halted(ht1), .stall_cnt(cn1)
  );

  stall_ctrl_unit #(.CNT_W(4)) u_dut_c4 (
    .clk(clk), .reset(reset), .op(op), .valid(valid), .resume(resume),
    .clr_cnt(clr_cnt), .stall(st2), .stall_pm(pm2), .halted(ht2), .stall_cnt(cn2)
  );

  task automatic add(input int seg, input logic rst, input logic [5:0] o,
                     input logic v, input logic r, input logic c, input int sel,
                     input logic chk, input logic es, input logic ep,
                     input logic eh, input logic [15:0] ec);
    vec_t t;
    t.seg = seg; t.rst = rst; t.op = o; t.vld = v; t.res = r; t.clr = c;
    t.sel = sel; t.chk = chk; t.e_stall = es; t.e_pm = ep; t.e_halt = eh;
    t.e_cnt = ec;
    vecs.push_back(t);
  endtask

  task automatic check(input vec_t e, input int row);
    logic        a_st, a_pm, a_ht;
    logic [15:0] a_cn;
    case (e.sel)
      1:       begin a_st = st1; a_pm = pm1; a_ht = ht1; a_cn = cn1; end
      2:       begin a_st = st2; a_pm = pm2; a_ht = ht2; a_cn = {12'd0, cn2}; end
      default: begin a_st = st0; a_pm = pm0; a_ht = ht0; a_cn = cn0; end
    endcase
    n_checks += 4;
    if (a_st !== e.e_stall) begin
      n_errors++;
      $display("FAIL seg%0d.row%0d stall: got %b exp %b", e.seg, row, a_st, e.e_stall);
    end
    if (a_pm !== e.e_pm) begin
      n_errors++;
      $display("FAIL seg%0d.row%0d stall_pm: got %b exp %b", e.seg, row, a_pm, e.e_pm);
    end
    if (a_ht !== e.e_halt) begin
      n_errors++;
      $display("FAIL seg%0d.row%0d halted: got %b exp %b", e.seg, row, a_ht, e.e_halt);
    end
    if (a_cn !== e.e_cnt) begin
      n_errors++;
      $display("FAIL seg%0d.row%0d stall_cnt: got %0d exp %0d", e.seg, row, a_cn, e.e_cnt);
    end
  endtask

  initial begin
    vec_t e;

    // seg 1: reset held with a load present
    add(1, 1, c_ld, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, c_ld, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, c_ld, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, c_ld, 1, 0, 0, 2, 1, 0, 0, 0, 0);

    // seg 2: load, defaults; then valid=0 masks the hazard
    add(2, 0, c_ld,  1, 0, 0, 0, 1, 1, 0, 0, 0);
    add(2, 0, c_ld,  1, 0, 0, 0, 1, 0, 1, 0, 1);
    add(2, 0, c_nop, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    add(2, 0, c_ld,  0, 0, 0, 0, 1, 0, 0, 0, 1);

    // seg 3: jump, defaults
    add(3, 1, c_nop, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    add(3, 0, c_jmp, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    add(3, 0, c_jmp, 1, 0, 0, 0, 1, 1, 1, 0, 1);
    add(3, 0, c_jmp, 1, 0, 0, 0, 1, 0, 1, 0, 2);
    add(3, 0, c_nop, 1, 0, 0, 0, 1, 0, 0, 0, 2);

    // seg 4: jump, JMP_CYC=4; resume in WAIT is ignored
    add(4, 1, c_nop, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(4, 1, c_nop, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(4, 0, c_jmx, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    add(4, 0, c_jmx, 1, 1, 0, 1, 1, 1, 1, 0, 1);
    add(4, 0, c_jmx, 1, 0, 0, 1, 1, 1, 1, 0, 2);
    add(4, 0, c_jmx, 1, 0, 0, 1, 1, 1, 1, 0, 3);
    add(4, 0, c_jmx, 1, 0, 0, 1, 1, 0, 1, 0, 4);
    add(4, 0, c_nop, 1, 0, 0, 1, 1, 0, 0, 0, 4);

    // seg 5: halt/resume, PASS ignores a hazard, next IDLE catches one
    add(5, 1, c_nop, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(5, 1, c_nop, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(5, 0, c_hlt, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    add(5, 0, c_hlt, 1, 0, 0, 0, 1, 1, 1, 1, 1);
    add(5, 0, c_hlt, 1, 0, 0, 0, 1, 1, 1, 1, 2);
    add(5, 0, c_hlt, 1, 0, 0, 0, 1, 1, 1, 1, 3);
    add(5, 0, c_hlt, 1, 1, 0, 0, 1, 1, 1, 1, 4);
    add(5, 0, c_hlt, 1, 0, 0, 0, 1, 0, 1, 1, 5);
    add(5, 0, c_ld,  1, 0, 0, 0, 1, 1, 0, 0, 5);
    add(5, 0, c_nop, 1, 0, 0, 0, 1, 0, 1, 0, 6);
    add(5, 0, c_nop, 1, 0, 0, 0, 1, 0, 0, 0, 6);

    // seg 6: reset in the 2nd stall cycle of a JMP_CYC=4 jump
    add(6, 1, c_nop, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(6, 1, c_nop, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(6, 0, c_jmp, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    add(6, 1, c_jmp, 1, 0, 0, 1, 1, 0, 1, 0, 1);
    add(6, 0, c_nop, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(6, 0, c_nop, 1, 0, 0, 1, 1, 0, 0, 0, 0);

    // seg 7: CNT_W=4 saturation under a long halt, then clear with stall=1
    add(7, 1, c_nop, 1, 0, 0, 2, 0, 0, 0, 0, 0);
    add(7, 1, c_nop, 1, 0, 0, 2, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      add(7, 0, c_hlt, 1, 0, 0, 2, 1, 1, (k > 1), (k > 1),
          16'((k - 1 > 15) ? 15 : k - 1));
    end
    add(7, 0, c_hlt, 1, 0, 1, 2, 1, 1, 1, 1, 15);
    add(7, 0, c_hlt, 1, 0, 0, 2, 1, 1, 1, 1, 0);
    add(7, 0, c_hlt, 1, 0, 0, 2, 1, 1, 1, 1, 1);
    // reset while halted aborts the halt
    add(7, 1, c_nop, 1, 0, 0, 2, 1, 0, 1, 1, 2);
    add(7, 0, c_nop, 1, 0, 0, 2, 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset   = vecs[i].rst;
      op      = vecs[i].op;
      valid   = vecs[i].vld;
      resume  = vecs[i].res;
      clr_cnt = vecs[i].clr;
      sb.push_back(vecs[i]);
      @(negedge clk);
      #1;
      e = sb.pop_front();
      if (e.chk) check(e, i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stall_ctrl_unit.md
STALL_CTRL_UNIT -- requirements
Module: stall_ctrl_unit

Interface
REQ-001 Parameter OP_W, default 6, opcode width.
REQ-002 Parameter OP_HLT, default 6'b010001, halt opcode (full match).
REQ-003 Parameter OP_LD, default 6'b010100, load opcode (full match).
REQ-004 Parameter JMP_MASK / JMP_MATCH, default 6'b111100 / 6'b011100, jump detected when (op & JMP_MASK) == JMP_MATCH.
REQ-005 Parameter LD_CYC, default 1, legal 1..15, stall cycles per load.
REQ-006 Parameter JMP_CYC, default 2, legal 1..15, stall cycles per jump.
REQ-007 Parameter CNT_W, default 16, stall-counter width.
REQ-008 clk  input  1  single clock; all state updates on its rising edge.
REQ-009 reset  input  1  synchronous, active-high; sampled at the rising edge of clk.
REQ-010 op  input  OP_W  opcode of the instruction in decode; held stable by the pipeline while stall=1.
REQ-011 valid  input  1  op qualifies as a real instruction.
REQ-012 resume  input  1  one-cycle pulse releasing the HALT state.
REQ-013 clr_cnt  input  1  synchronous clear of stall_cnt.
REQ-014 stall  output  1  combinational stall to the PC and IF/ID stages.
REQ-015 stall_pm  output  1  stall registered one cycle, used by the program-memory stage.
REQ-016 halted  output  1  registered; high while the FSM is in HALT.
REQ-017 stall_cnt  output  CNT_W  count of cycles with stall=1, saturating.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT, HALT and PASS, plus an internal 4-bit down-counter rem.
REQ-019 Hazard terms: hit_h = valid & op==OP_HLT, hit_l = valid & op==OP_LD, hit_j = valid & jump-match; priority is HLT > LD > JMP.
REQ-020 IDLE: stall = hit_h|hit_l|hit_j.
REQ-021 IDLE on hit_h: next state HALT.
REQ-022 IDLE on hit_l (or hit_j): rem <= LD_CYC-1 (or JMP_CYC-1); next state WAIT if that value is nonzero, else PASS.
REQ-023 WAIT: stall=1; rem decrements; when rem==1 the next state is PASS, otherwise the FSM stays in WAIT.
REQ-024 A hazard SHALL therefore stall for exactly LD_CYC or JMP_CYC cycles, counting the detection cycle.
REQ-025 PASS: stall=0 and hazard detection is suppressed, so the held instruction proceeds; next state is IDLE unconditionally.
REQ-026 HALT: stall=1 every cycle; resume=1 moves the FSM to PASS, otherwise it stays in HALT.
REQ-027 resume SHALL be ignored in every state other than HALT.
REQ-028 valid=0 in IDLE SHALL produce stall=0, whatever op is.
REQ-029 stall_pm SHALL equal stall from the previous cycle.
REQ-030 halted SHALL be 1 in the cycle after entry to HALT and 0 in the cycle after leaving it.
REQ-031 stall_cnt SHALL increment by 1 in each cycle with stall=1 and hold at 2^CNT_W-1.
REQ-032 clr_cnt=1 SHALL set stall_cnt to 0 on the next edge, overriding any increment in the same cycle.
REQ-033 Consecutive hazards: a new hazard op presented in the PASS cycle is ignored; it is detected in the following IDLE cycle if still present.

Reset
REQ-034 reset=1 at a clock edge SHALL force: state IDLE, rem 0, stall_pm 0, halted 0, stall_cnt 0.
REQ-035 reset SHALL take priority over resume, clr_cnt and all FSM transitions.
REQ-036 A reset in WAIT or HALT SHALL abort the sequence; stall follows the IDLE rule from the next cycle.
REQ-037 While reset=1, stall SHALL be forced to 0.

Verification
REQ-038 Reset: hold reset 3 cycles with op=OP_LD, valid=1 -> stall, stall_pm, halted and stall_cnt all 0.
REQ-039 Load, defaults: op=6'b010100 held, valid=1 -> stall 1,0 and IDLE; stall_pm 0,1,0; stall_cnt=1.
REQ-040 Jump, defaults: op=6'b011100 held -> stall 1,1,0; stall_pm 0,1,1,0; stall_cnt=2. Repeat with JMP_CYC=4 -> stall 1,1,1,1,0.
REQ-041 Halt/resume: op=6'b010001 -> stall=1 continuously and halted=1 from cycle 2; resume pulse at cycle 5 -> cycle 6 PASS with stall=0; halted=0 from cycle 7.
REQ-042 Mid-sequence reset: JMP_CYC=4, reset asserted in the 2nd stall cycle -> next cycle IDLE, stall_cnt=0, no residual stall once op goes to a NOP.
REQ-043 Counter: CNT_W=4, 20 halt cycles -> stall_cnt=15 and holds; clr_cnt together with stall=1 -> stall_cnt=0.
